// File: rtl/int8_mac_pkg.sv
// Shared defaults and FSM encoding for the int8 MAC partial-sum accumulator.
package int8_mac_pkg;

    localparam int PSUM_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/int8_psum_accumulator_sat_clamp.sv
// Clamps a wide signed accumulator to the signed PSUM_W range and flags clamping.
module sat_clamp #(
    parameter int ACC_W  = 40,
    parameter int PSUM_W = 32
) (
    input  logic signed [ACC_W-1:0]  din,
    output logic signed [PSUM_W-1:0] dout,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

    always_comb begin
        dout = din[PSUM_W-1:0];
        sat  = 1'b0;
        if (din > MAX_V) begin
            dout = MAX_V[PSUM_W-1:0];
            sat  = 1'b1;
        end else if (din < MIN_V) begin
            dout = MIN_V[PSUM_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/int8_psum_accumulator.sv
// Sums groups of cfg_len signed partial sums and emits one saturated result per group.
module int8_psum_accumulator
    import int8_mac_pkg::*;
#(
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [PSUM_W-1:0] in_psum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [PSUM_W-1:0] out_data,
    output logic                     out_sat,
    output logic                     busy
);

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [ACC_W-1:0]   acc_next, psum_ext;
    logic [LEN_W-1:0]          cnt_q, cnt_d, len_q, len_d;
    logic [LEN_W-1:0]          len_eff, cnt_inc;
    logic                      out_valid_q, out_valid_d;
    logic                      out_sat_q, out_sat_d;
    logic signed [PSUM_W-1:0]  out_data_q, out_data_d;
    logic signed [PSUM_W-1:0]  clamp_val;
    logic                      clamp_sat;
    logic                      accept;

    assign in_ready  = (state_q != ST_HOLD);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign psum_ext  = ACC_W'(in_psum);

    // The clamp sees the post-beat sum so the result can register on the closing beat.
    always_comb begin
        len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        cnt_inc  = cnt_q + LEN_W'(1);
        acc_next = (state_q == ST_IDLE) ? psum_ext : (acc_q + psum_ext);
    end

    sat_clamp #(
        .ACC_W  (ACC_W),
        .PSUM_W (PSUM_W)
    ) u_sat_clamp (
        .din  (acc_next),
        .dout (clamp_val),
        .sat  (clamp_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    len_d = len_eff;
                    acc_d = acc_next;
                    cnt_d = LEN_W'(1);
                    if (len_eff == LEN_W'(1)) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = clamp_val;
                        out_sat_d   = clamp_sat;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = acc_next;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = clamp_val;
                        out_sat_d   = clamp_sat;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_int8_psum_accumulator.sv
// Scoreboard bench for int8_psum_accumulator: directed cases plus randomized groups.
module tb_int8_psum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cfg_len;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_psum;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        busy;

    typedef struct packed {
        logic [31:0] data;
        logic        sat;
    } exp_t;

    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    exp_t sb[$];
    exp_t mon_e;
    int   gv[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   rnd_on = 1'b0;

    int8_psum_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    // Reference: 40-bit wrapping sum of the group, then clamp to 32-bit signed.
    function automatic exp_t ref_group();
        longint acc;
        exp_t   r;
        acc = 0;
        foreach (gv[i]) acc += longint'(gv[i]);
        acc = (acc <<< 24) >>> 24;
        if (acc > SMAX) begin
            r.data = 32'h7FFFFFFF;
            r.sat  = 1'b1;
        end else if (acc < SMIN) begin
            r.data = 32'h80000000;
            r.sat  = 1'b1;
        end else begin
            r.data = acc[31:0];
            r.sat  = 1'b0;
        end
        return r;
    endfunction

    task automatic beat(input logic [31:0] v, output int stalls);
        in_valid = 1'b1;
        in_psum  = v;
        stalls   = 0;
        while (!in_ready) begin
            @(posedge clk); #1;
            stalls++;
            if (stalls > 500) begin
                $display("FAIL beat_timeout: got %0d stall cycles, required at most 500", stalls);
                n_fail++;
                $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                $fatal(1, "input stalled");
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_group(input int cfg, input bit gaps);
        int st;
        sb.push_back(ref_group());
        cfg_len = cfg[7:0];
        foreach (gv[i]) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                end
            end
            beat(gv[i], st);
            if (gaps && i == 0) cfg_len = 8'($urandom);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_out_data", {32'd0, out_data}, {32'd0, mon_e.data});
                chk("sb_out_sat", {63'd0, out_sat}, {63'd0, mon_e.sat});
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        int st;
        int c;
        int eff;
        int s;
        byte a;
        byte b;

        rst = 1'b1; cfg_len = 8'd0; in_valid = 1'b0; in_psum = 32'd0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_sat", {63'd0, out_sat}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Four-beat group, result visible right after the closing beat.
        gv = '{100, -50, 7, 1};
        sb.push_back(ref_group());
        cfg_len = 8'd4;
        foreach (gv[i]) begin
            beat(gv[i], st);
            if (i < 3) chk("t1_no_early_valid", {63'd0, out_valid}, 64'd0);
        end
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_data", {32'd0, out_data}, 64'd58);
        chk("t1_sat", {63'd0, out_sat}, 64'd0);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        chk("t1_valid_clr", {63'd0, out_valid}, 64'd0);
        chk("t1_idle", {63'd0, busy}, 64'd0);

        // cfg_len 0 behaves as 1; back-to-back singles are two cycles apart.
        cfg_len = 8'd0;
        for (int k = 0; k < 3; k++) begin
            gv = '{-25};
            sb.push_back(ref_group());
            beat(32'hFFFFFFE7, st);
            if (k > 0) chk("t2_spacing", 64'(st), 64'd1);
            chk("t2_valid", {63'd0, out_valid}, 64'd1);
            chk("t2_data", {32'd0, out_data}, {32'd0, 32'hFFFFFFE7});
        end

        // Saturation at both ends.
        gv = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF};
        send_group(3, 1'b0);
        chk("t3_pos_data", {32'd0, out_data}, {32'd0, 32'h7FFFFFFF});
        chk("t3_pos_sat", {63'd0, out_sat}, 64'd1);
        gv = '{32'h80000000, 32'h80000000, 32'h80000000};
        send_group(3, 1'b0);
        chk("t3_neg_data", {32'd0, out_data}, {32'd0, 32'h80000000});
        chk("t3_neg_sat", {63'd0, out_sat}, 64'd1);
        @(posedge clk); #1;

        // Backpressure: output held, input stalled and ignored.
        out_ready = 1'b0;
        gv = '{10, 20};
        send_group(2, 1'b0);
        in_valid = 1'b1;
        in_psum  = 32'd999;
        repeat (5) begin
            chk("t4_in_ready", {63'd0, in_ready}, 64'd0);
            chk("t4_valid", {63'd0, out_valid}, 64'd1);
            chk("t4_data", {32'd0, out_data}, 64'd30);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_valid_clr", {63'd0, out_valid}, 64'd0);
        chk("t4_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of a group.
        cfg_len = 8'd4;
        beat(32'd1, st);
        beat(32'd2, st);
        #2 rst = 1'b1;
        #1;
        chk("t5_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_busy", {63'd0, busy}, 64'd0);
        chk("t5_data", {32'd0, out_data}, 64'd0);
        chk("t5_sat", {63'd0, out_sat}, 64'd0);
        chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        gv = '{9};
        send_group(1, 1'b0);
        chk("t5_new_group", {32'd0, out_data}, 64'd9);
        @(posedge clk); #1;

        // Randomized groups with input gaps and output backpressure.
        rnd_on = 1'b1;
        for (int g = 0; g < 1000; g++) begin
            c = ($urandom_range(0, 7) == 0) ? $urandom_range(9, 20) : $urandom_range(0, 8);
            eff = (c == 0) ? 1 : c;
            gv.delete();
            for (int i = 0; i < eff; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    s = int'($urandom);
                end else begin
                    s = 0;
                    for (int k = 0; k < 4; k++) begin
                        a = byte'($urandom);
                        b = byte'($urandom);
                        s += a * b;
                    end
                end
                gv.push_back(s);
            end
            send_group(c, 1'b1);
        end
        rnd_on = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 50 && sb.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/int8_psum_accumulator.md
INT8_PSUM_ACCUMULATOR -- requirements
Module: int8_psum_accumulator

Interface
REQ-001 Parameter PSUM_W, default 32: width of the signed partial sum taken from the int8 MAC tree.
REQ-002 Parameter ACC_W, default 40: width of the internal signed accumulator.
REQ-003 Parameter LEN_W, default 8: width of the group-length field.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cfg_len  input  LEN_W  number of partial sums per output group.
REQ-007 in_valid  input  1  in_psum is valid this cycle.
REQ-008 in_ready  output  1  block accepts in_psum this cycle.
REQ-009 in_psum  input  PSUM_W  signed partial sum, i.e. one MAC-tree dot product.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  downstream accepts out_data.
REQ-012 out_data  output  PSUM_W  signed, saturated group sum.
REQ-013 out_sat  output  1  out_data was clamped; qualified by out_valid.
REQ-014 busy  output  1  a group is in progress or held.

Function
REQ-015 An input beat is accepted only on a cycle where in_valid and in_ready are both 1.
REQ-016 The FSM has three states: IDLE, ACCUM and HOLD.
REQ-017 in_ready is 1 in IDLE and ACCUM and 0 in HOLD.
REQ-018 In IDLE, an accepted beat latches the group length: len = cfg_len, with cfg_len 0 treated as 1.
REQ-019 In IDLE, the accepted beat also loads acc = sext(in_psum) and beat count = 1.
REQ-020 In IDLE, after an accepted beat, the FSM goes to HOLD if len == 1 and to ACCUM otherwise.
REQ-021 In ACCUM, each accepted beat does acc = acc + sext(in_psum) and increments the count.
REQ-022 In ACCUM, the beat that makes count == len moves the FSM to HOLD.
REQ-023 Changes to cfg_len after a group has started have no effect on that group.
REQ-024 Accumulation runs at full ACC_W width with two's-complement wrap, and it never saturates internally.
REQ-025 On entry to HOLD, out_data is registered as acc clamped to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1].
REQ-026 out_sat is 1 when that clamp changed the value and 0 otherwise.
REQ-027 Latency: out_valid rises on the clock edge that accepts the group's last beat, so it is visible in the next cycle.
REQ-028 In HOLD, out_valid is 1 and out_data and out_sat stay stable until out_ready is 1.
REQ-029 An out_valid && out_ready handshake returns the FSM to IDLE and clears out_valid.
REQ-030 A new group's first beat can be accepted no earlier than the cycle after the output handshake.
REQ-031 Without backpressure, a group of N beats needs N+1 cycles.
REQ-032 in_valid without in_ready (the HOLD state) is ignored: no state change and no loss, because the upstream stage holds the data.
REQ-033 Cycles in ACCUM with in_valid 0 leave acc and the count unchanged.
REQ-034 busy is 1 whenever the state is not IDLE.

Reset
REQ-035 Asserting rst forces state IDLE, acc 0, count 0, len 0, out_valid 0, out_data 0, out_sat 0 and busy 0, regardless of the clock.
REQ-036 A reset during ACCUM or HOLD discards the partial group and produces no output.
REQ-037 After rst deasserts, the first accepted beat starts a new group.

Structure
REQ-038 A shared package int8_mac_pkg holds PSUM_W, ACC_W, LEN_W defaults and the FSM state encoding constants.
REQ-039 The saturating clamp is one sub-module, sat_clamp, with a signed input of ACC_W bits and outputs PSUM_W value plus a sat flag.
REQ-040 The block is otherwise flat, with registered outputs only and no combinational path from in_psum to out_data.

Verification
REQ-041 Reset, then cfg_len=4 with psums 100, -50, 7, 1 sent back-to-back and out_ready=1 -> out_data=58, out_sat=0, and out_valid one cycle after the 4th beat.
REQ-042 cfg_len=0 with a single beat -25 -> one output of -25; repeat 3 times back-to-back -> each output 2 cycles apart.
REQ-043 cfg_len=3 with three beats of 0x7FFFFFFF -> out_data=0x7FFFFFFF, out_sat=1; three beats of 0x80000000 -> out_data=0x80000000, out_sat=1.
REQ-044 cfg_len=2 with beats 10, 20 and out_ready=0 for 5 cycles -> in_ready=0 and out_data held at 30 throughout, then one handshake, then IDLE.
REQ-045 cfg_len=4, two beats accepted, then rst pulsed mid-cycle -> outputs clear immediately; a following group of cfg_len=1 with beat 9 -> out_data=9.
REQ-046 Random scoreboard: 1000 groups with random cfg_len, random in_valid and out_ready gaps, and random int8 dot products -> every out_data matches the clamped reference sum.
